muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Parametrised multi-cycle multiply/divide unit that owns the HI/LO special-purpose registers.
//   Performs signed/unsigned MULT and DIV by radix-2 shift-add / restoring division: WIDTH iterations.
//   Moves operands into HI/LO in a single cycle (MTHI/MTLO).
//   Sits beside the ALU in the execute stage; the core stalls MFHI/MFLO and new mul/div ops while busy=1.
// PARAMETERS
//   WIDTH     32   operand, HI and LO width in bits (>=4)
//   CNT_W     $clog2(WIDTH+1)   iteration counter width (derived, do not override)
// PORTS
//   clock     in   1       single clock; all state updates on posedge
//   reset     in   1       asynchronous, active-high; clears all state immediately
//   start     in   1       request; sampled on posedge, accepted only when busy=0
//   op        in   3       000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
//   a         in   WIDTH   multiplicand / dividend / MTHI-MTLO source
//   b         in   WIDTH   multiplier / divisor
//   busy      out  1       operation in progress; start is ignored while high
//   done      out  1       one-cycle pulse: HI/LO hold the new result
//   div0      out  1       one-cycle pulse with done when a DIV/DIVU had b==0
//   hi        out  WIDTH   HI register (product upper half / remainder)
//   lo        out  WIDTH   LO register (product lower half / quotient)
// BEHAVIOUR
//   Reset: state=IDLE; hi=lo=0; busy=done=div0=0; counter and datapath cleared. Applies mid-operation too.
//   States: IDLE, RUN, FIN.
//   IDLE:
//     start & op in {000..011}: latch |a|, |b| (magnitudes only for signed ops) and result-sign flags;
//       counter=WIDTH; busy=1; go to RUN.
//     start & op=MTHI: hi<=a, done pulse next cycle, stay IDLE, busy stays 0. MTLO: same, writes lo.
//     start & op=11x, or start=0: no effect.
//   RUN: one iteration per clock; counter decrements; at counter==1 the last iteration runs, go to FIN.
//   FIN:
//     apply sign correction; write hi/lo; done=1 (and div0 if applicable) for exactly one cycle.
//     busy=0 during that same cycle; go to IDLE.
//   Latency: start accepted at edge 0 -> hi/lo/done update at edge WIDTH+1.
//     busy is high from edge 0 until edge WIDTH+1.
//     A start in the done cycle is accepted (back-to-back issue, period WIDTH+1).
//   hi/lo hold their previous values throughout RUN; only FIN, MTHI and MTLO write them.
//   Multiply: 2*WIDTH-bit product; hi=upper WIDTH bits, lo=lower WIDTH bits.
//     MULT negates the 2*WIDTH-bit product when sign(a)!=sign(b).
//   Divide:
//     quotient negative iff sign(a)!=sign(b) and b!=0; remainder takes the sign of the dividend.
//     Results satisfy a == lo*b + hi.
//   Divide by zero (b==0, both DIV and DIVU): lo={WIDTH{1}}, hi=a (original, unsigned view), div0=1 with done.
//     Takes the full WIDTH+1 latency.
//   Signed overflow: DIV with a=most-negative and b=-1 gives lo=most-negative, hi=0, div0=0 (natural wrap).
//   Operand change: a/b may change after the accepting edge without affecting the result.
//   Simultaneous events:
//     reset dominates start;
//     start in FIN is ignored (busy is 0 only in the done cycle, which is IDLE);
//     MTHI/MTLO are ignored while busy=1.
// TESTING (WIDTH=32)
//   1 MULTU a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE lo=00000001; done exactly 33 edges after the start edge.
//   2 MULT a=FFFFFFFD(-3) b=00000007 -> hi=FFFFFFFF lo=FFFFFFEB; then DIVU a=100 b=7 -> lo=14 hi=2.
//   3 DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD hi=FFFFFFFF; DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=0.
//   4 DIV a=00001234 b=0 -> lo=FFFFFFFF hi=00001234, div0=1 for one cycle coincident with done.
//   5 MULT busy, then start DIVU and MTHI mid-run -> both ignored, original product delivered, hi unchanged until FIN.
//     Then start MTLO a=5 in the done cycle -> lo=5 next edge.
//   6 Assert reset asynchronously at RUN iteration 10 -> busy=done=0 and hi=lo=0 without a clock edge.
//     Release reset, then MULTU 6*7 -> lo=42 hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle signed/unsigned multiply/divide unit owning the HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   p;
    logic [WIDTH-1:0]     m;
    logic                 is_div, neg_q, neg_r, bz;
    logic                 accept, mt;
    logic [WIDTH-1:0]     ma, mb;
    logic [WIDTH:0]       sum, t, diff;
    logic [2*WIDTH-1:0]   p_mul, p_div, res_mul;
    logic [WIDTH-1:0]     q_fin, r_fin;

    assign busy = state != IDLE;

    // next state plus the combinational pieces of one shift-add / restoring-divide iteration
    always_comb begin
        accept   = start && state == IDLE && !op[2];
        mt       = start && state == IDLE && op[2:1] == 2'b10;
        state_nx = accept ? RUN : (state == RUN && cnt == CNT_W'(1)) ? FIN : state == FIN ? IDLE : state;
        ma       = (!op[0] && a[WIDTH-1]) ? -a : a;
        mb       = (!op[0] && b[WIDTH-1]) ? -b : b;
        sum      = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        p_mul    = {sum, p[WIDTH-1:1]};
        t        = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        diff     = t - {1'b0, m};
        p_div    = diff[WIDTH] ? {t[WIDTH-1:0], p[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        res_mul  = neg_q ? -p : p;
        q_fin    = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        r_fin    = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    end

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // operand latch, iteration datapath and HI/LO write-back
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            p      <= '0;
            m      <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            bz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            div0   <= 1'b0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            if (accept) begin
                p      <= op[1] ? {{WIDTH{1'b0}}, ma} : {{WIDTH{1'b0}}, mb};
                m      <= op[1] ? mb : ma;
                cnt    <= CNT_W'(WIDTH);
                is_div <= op[1];
                neg_q  <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]) && |b;
                neg_r  <= !op[0] && a[WIDTH-1];
                bz     <= b == '0;
            end
            if (mt) begin
                if (op[0]) lo <= a;
                else       hi <= a;
                done <= 1'b1;
            end
            if (state == RUN) begin
                p   <= is_div ? p_div : p_mul;
                cnt <= cnt - 1'b1;
            end
            if (state == FIN) begin
                hi   <= is_div ? r_fin : res_mul[2*WIDTH-1:WIDTH];
                lo   <= is_div ? q_fin : res_mul[WIDTH-1:0];
                done <= 1'b1;
                div0 <= is_div && bz;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div0;
    logic [W-1:0] hi, lo;
    logic [W-1:0] mh = '0;
    logic [W-1:0] ml = '0;
    int           n_run = 0;
    int           n_fail = 0;

    always #5 clock = ~clock;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  inout logic [W-1:0] h, inout logic [W-1:0] l, output bit z);
        longint sx, sy, q, r;
        longint unsigned ux, uy, uq, ur, pr;
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        z = 0;
        case (o)
            3'd0: begin pr = sx * sy; h = pr[63:32]; l = pr[31:0]; end
            3'd1: begin pr = ux * uy; h = pr[63:32]; l = pr[31:0]; end
            3'd2, 3'd3: begin
                if (y == 0) begin
                    h = x; l = '1; z = 1;
                end else if (o == 3'd2) begin
                    q = sx / sy; r = sx % sy; h = r[31:0]; l = q[31:0];
                end else begin
                    uq = ux / uy; ur = ux % uy; h = ur[31:0]; l = uq[31:0];
                end
            end
            3'd4: h = x;
            3'd5: l = x;
            default: ;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock);
        #1;
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(input logic [W-1:0] h0, input logic [W-1:0] l0, output int n);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
            if (!done) begin
                chk("hold_hi", hi, h0);
                chk("hold_lo", lo, l0);
            end
        end while (!done && n < 60);
        if (!done) chk("timeout_done", done, 1);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] h0, l0;
        bit z;
        int n;
        h0 = mh;
        l0 = ml;
        model(o, x, y, mh, ml, z);
        issue(o, x, y);
        if (o[2]) begin
            chk("mt_done", done, o[1] ? 0 : 1);
            chk("mt_busy", busy, 0);
            chk("mt_hi", hi, mh);
            chk("mt_lo", lo, ml);
            @(posedge clock);
            #1;
            chk("mt_done_clr", done, 0);
        end else begin
            chk("busy", busy, 1);
            wait_done(h0, l0, n);
            chk("latency", n, W + 1);
            chk("hi", hi, mh);
            chk("lo", lo, ml);
            chk("div0", div0, z);
            chk("busy_fin", busy, 0);
            @(posedge clock);
            #1;
            chk("done_clr", done, 0);
            chk("div0_clr", div0, 0);
        end
    endtask

    initial begin
        logic [2:0] o;
        logic [W-1:0] x, y, h0;
        bit z;
        int n;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div0", div0, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        @(negedge clock);
        reset = 1'b0;

        do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        do_op(3'd0, 32'hFFFFFFFD, 32'h00000007);
        do_op(3'd3, 32'd100, 32'd7);
        do_op(3'd2, 32'hFFFFFFF9, 32'd2);
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
        do_op(3'd2, 32'h00001234, 32'd0);
        do_op(3'd3, 32'h80001234, 32'd0);
        do_op(3'd2, 32'hF0001234, 32'd0);
        do_op(3'd6, 32'h11111111, 32'd3);

        h0 = mh;
        model(3'd0, 32'hFFFFFFFD, 32'd7, mh, ml, z);
        issue(3'd0, 32'hFFFFFFFD, 32'd7);
        repeat (5) @(posedge clock);
        issue(3'd3, 32'd9, 32'd3);
        chk("ign_busy", busy, 1);
        chk("ign_hi", hi, h0);
        issue(3'd4, 32'hDEADBEEF, 32'd0);
        chk("ign_mthi", hi, h0);
        wait_done(h0, lo, n);
        chk("ign_res_hi", hi, mh);
        chk("ign_res_lo", lo, ml);
        start = 1'b1; op = 3'd5; a = 32'd5;
        @(posedge clock);
        #1;
        start = 1'b0;
        ml = 32'd5;
        chk("b2b_lo", lo, 5);
        chk("b2b_done", done, 1);
        chk("b2b_hi", hi, mh);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 4))
                0: y = '0;
                1: y = '1;
                2: y = $urandom_range(1, 15);
                default: y = $urandom;
            endcase
            do_op(o, x, y);
        end

        issue(3'd1, 32'h12345, 32'h54321);
        repeat (9) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        mh = '0;
        ml = '0;
        @(negedge clock);
        reset = 1'b0;
        do_op(3'd1, 32'd6, 32'd7);
        chk("final_lo", lo, 42);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
